// File: rtl/mcd212_pkg.sv
// rtl/mcd212_pkg.sv - shared types for the MCD212 RAM arbiter
package mcd212_pkg;

  localparam int RAM_AW = 19;
  localparam int RAM_DW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_VID0,
    GNT_VID1
  } arb_grant_t;

  function automatic logic is_video(input arb_grant_t g);
    return (g == GNT_VID0) || (g == GNT_VID1);
  endfunction

endpackage

// File: rtl/mcd212_ram_arbiter_if.sv
// rtl/mcd212_ram_arbiter_if.sv - CPU, video and RAM port bundle of the arbiter
interface mcd212_ram_arbiter_if;
  import mcd212_pkg::*;

  logic              display_active;

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [RAM_AW-1:0] cpu_addr;
  logic [RAM_DW-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [RAM_DW-1:0] cpu_rdata;

  logic              vid0_req;
  logic [RAM_AW-1:0] vid0_addr;
  logic              vid0_ack;
  logic [RAM_DW-1:0] vid0_rdata;

  logic              vid1_req;
  logic [RAM_AW-1:0] vid1_addr;
  logic              vid1_ack;
  logic [RAM_DW-1:0] vid1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [RAM_AW-1:0] mem_addr;
  logic [RAM_DW-1:0] mem_wdata;
  logic [RAM_DW-1:0] mem_rdata;

  modport slave (
    input  display_active,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  vid0_req, vid0_addr,
    output vid0_ack, vid0_rdata,
    input  vid1_req, vid1_addr,
    output vid1_ack, vid1_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output display_active,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output vid0_req, vid0_addr,
    input  vid0_ack, vid0_rdata,
    output vid1_req, vid1_addr,
    input  vid1_ack, vid1_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mcd212_arb_pick.sv
// rtl/mcd212_arb_pick.sv - combinational display-aware priority and video round-robin
module mcd212_arb_pick
  import mcd212_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       vid0_req_i,
  input  logic       vid1_req_i,
  input  logic       display_active_i,
  input  logic       rr_last_i,
  input  logic       cpu_force_i,
  output arb_grant_t grant_o
);

  arb_grant_t vid_pick;

  always_comb begin
    vid_pick = GNT_NONE;
    // rr_last_i = 1 means vid1 was served last, so vid0 gets the tie
    if (vid0_req_i && vid1_req_i) begin
      vid_pick = rr_last_i ? GNT_VID0 : GNT_VID1;
    end else if (vid0_req_i) begin
      vid_pick = GNT_VID0;
    end else if (vid1_req_i) begin
      vid_pick = GNT_VID1;
    end

    grant_o = GNT_NONE;
    if (display_active_i) begin
      if (cpu_force_i) begin
        grant_o = GNT_CPU;
      end else if (vid_pick != GNT_NONE) begin
        grant_o = vid_pick;
      end else if (cpu_req_i) begin
        grant_o = GNT_CPU;
      end
    end else begin
      grant_o = cpu_req_i ? GNT_CPU : vid_pick;
    end
  end

endmodule

// File: rtl/mcd212_ram_arbiter.sv
// rtl/mcd212_ram_arbiter.sv - single registered RAM port shared by CPU and two video fetch channels
module mcd212_ram_arbiter
  import mcd212_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  mcd212_ram_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant_q, grant_d, pick;
  logic              rr_last_q, rr_last_d;
  logic [3:0]        wait_q, wait_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [RAM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [RAM_DW-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid0_ack_q, vid0_ack_d;
  logic              vid1_ack_q, vid1_ack_d;
  logic              cpu_force;

  assign cpu_force = bus.cpu_req && (wait_q == WAIT_MAX);

  mcd212_arb_pick u_pick (
    .cpu_req_i        (bus.cpu_req),
    .vid0_req_i       (bus.vid0_req),
    .vid1_req_i       (bus.vid1_req),
    .display_active_i (bus.display_active),
    .rr_last_i        (rr_last_q),
    .cpu_force_i      (cpu_force),
    .grant_o          (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= GNT_NONE;
      rr_last_q   <= 1'b1;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid0_ack_q  <= 1'b0;
      vid1_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      wait_q      <= wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid0_ack_q  <= vid0_ack_d;
      vid1_ack_q  <= vid1_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick != GNT_NONE) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered memory command, acks and arbitration bookkeeping
  always_comb begin
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    wait_d      = wait_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    vid0_ack_d  = 1'b0;
    vid1_ack_d  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d  = pick;
          mem_en_d = 1'b1;
          mem_be_d = 2'b11;
          case (pick)
            GNT_CPU: begin
              mem_we_d    = bus.cpu_we;
              mem_be_d    = bus.cpu_be;
              mem_addr_d  = bus.cpu_addr;
              mem_wdata_d = bus.cpu_wdata;
            end
            GNT_VID0: mem_addr_d = bus.vid0_addr;
            default:  mem_addr_d = bus.vid1_addr;
          endcase
          if (is_video(pick)) rr_last_d = (pick == GNT_VID1);
        end
        if (pick == GNT_CPU) begin
          wait_d = '0;
        end else if (bus.cpu_req && (wait_q != WAIT_MAX)) begin
          wait_d = wait_q + 4'd1;
        end
      end
      ARB_ISSUE: begin
        cpu_ack_d  = (grant_q == GNT_CPU);
        vid0_ack_d = (grant_q == GNT_VID0);
        vid1_ack_d = (grant_q == GNT_VID1);
      end
      default: ;
    endcase

    if (!bus.cpu_req) wait_d = '0;
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.vid0_ack   = vid0_ack_q;
  assign bus.vid1_ack   = vid1_ack_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.vid0_rdata = bus.mem_rdata;
  assign bus.vid1_rdata = bus.mem_rdata;

endmodule
